// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared state encoding and width helpers for the burst backing memory.
// Contents:
//   state_t     FSM states of main_mem_burst
//   off_w()     beat-offset width, log2(line_words)
//   num_lines() number of lines in the array
//   lat_w()     width of the read-latency wait counter
package main_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        FLUSH
    } state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int num_lines(input int addr_width, input int line_words);
        return (1 << addr_width) / line_words;
    endfunction

    function automatic int lat_w(input int rd_latency);
        return $clog2(rd_latency + 1);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array: 2**AW x DW storage with a synchronous word read, a word write and a whole-line clear.
// Ports:
//   clk, rst                   clock; rst clears only the read data register, never the storage
//   i_rd_en, i_rd_addr         synchronous read; o_rd_data holds its value while i_rd_en is low
//   i_wr_en, i_wr_addr, i_wr_data  single-word write
//   i_clr_en, i_clr_line       zero all words of one line in a single cycle
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int OFF_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rd_en,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [DW-1:0]      o_rd_data,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [DW-1:0]      i_wr_data,
    input  logic               i_clr_en,
    input  logic [AW-OFF_W-1:0] i_clr_line
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_clr_en)
            for (int k = 0; k < 2**OFF_W; k++)
                r_mem[{i_clr_line, OFF_W'(k)}] <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_rd_data <= '0;
        else if (i_rd_en)
            o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/main_mem_burst.sv
// main_mem_burst: line-granular backing memory with burst refill/write-back and a hardware flush sweep.
// Optional feature macro: MAIN_MEM_STATS_EN adds saturating burst counters.
// Ports:
//   clk, rst                       clock; synchronous active-high reset (array contents kept)
//   i_flush                        request zeroing of the whole array
//   i_req_vld, o_req_rdy           request handshake
//   i_req_we                       1 = line write, 0 = line read
//   i_req_addr                     word address, low offset bits ignored
//   i_wr_data, i_wr_vld            write beats; i_wr_vld low stalls the burst
//   o_rd_data, o_rd_vld, o_rd_last read beats, no backpressure
//   o_wr_done                      one-cycle pulse after the final write beat commits
//   o_busy                         high in any state other than IDLE
//   o_rd_line_cnt, o_wr_line_cnt   completed read/write bursts (MAIN_MEM_STATS_EN only)
module main_mem_burst
    import main_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WORDS = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_req_vld,
    output logic                  o_req_rdy,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_vld,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_vld,
    output logic                  o_rd_last,
    output logic                  o_wr_done,
    output logic                  o_busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]           o_rd_line_cnt,
    output logic [31:0]           o_wr_line_cnt
`endif
);

    localparam int OFF_W     = off_w(LINE_WORDS);
    localparam int NUM_LINES = num_lines(ADDR_WIDTH, LINE_WORDS);
    localparam int LAT_W     = lat_w(RD_LATENCY);
    localparam int IDX_W     = ADDR_WIDTH - OFF_W;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_line, r_fl_line;
    logic [OFF_W-1:0] r_beat;
    logic [LAT_W-1:0] r_lat;
    logic             r_flush_pend, r_rd_vld, r_rd_last, r_wr_done;
    logic             w_accept, w_rd_en, w_wr_en, w_clr_en, w_rd_end, w_wr_end;
    logic             w_unused_off;

    // Requests are line aligned, so the offset bits of the address carry no information.
    assign w_unused_off = ^i_req_addr[OFF_W-1:0];

    assign o_req_rdy = !rst && r_state == IDLE && !i_flush && !r_flush_pend;
    assign o_busy    = r_state != IDLE;
    assign o_rd_vld  = r_rd_vld;
    assign o_rd_last = r_rd_last;
    assign o_wr_done = r_wr_done;
    assign w_rd_end  = w_rd_en && &r_beat;
    assign w_wr_end  = w_wr_en && &r_beat;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Storage strobes are gated by rst so a reset aborts a burst or sweep without touching the array.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_flush || r_flush_pend)
                    w_state_nxt = FLUSH;
                else if (i_req_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = i_req_we ? WR_BURST : (RD_LATENCY == 1 ? RD_BURST : RD_WAIT);
                end
            end
            RD_WAIT:  w_state_nxt = (r_lat == LAT_W'(RD_LATENCY - 2)) ? RD_BURST : RD_WAIT;
            RD_BURST: begin
                w_rd_en     = !rst;
                w_state_nxt = &r_beat ? IDLE : RD_BURST;
            end
            WR_BURST: begin
                w_wr_en     = i_wr_vld && !rst;
                w_state_nxt = (i_wr_vld && &r_beat) ? IDLE : WR_BURST;
            end
            FLUSH: begin
                w_clr_en    = !rst;
                w_state_nxt = (r_fl_line == IDX_W'(NUM_LINES - 1)) ? IDLE : FLUSH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beat and flush-line counters wrap to zero on their own after the last beat/line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line       <= '0;
            r_beat       <= '0;
            r_lat        <= '0;
            r_fl_line    <= '0;
            r_flush_pend <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_rd_last    <= 1'b0;
            r_wr_done    <= 1'b0;
        end else begin
            if (w_accept)
                r_line <= i_req_addr[ADDR_WIDTH-1:OFF_W];
            r_beat       <= r_beat + OFF_W'(w_rd_en | w_wr_en);
            r_lat        <= (r_state == RD_WAIT) ? r_lat + LAT_W'(1) : '0;
            r_fl_line    <= r_fl_line + IDX_W'(w_clr_en);
            r_flush_pend <= (r_state == FLUSH) ? 1'b0 : (r_flush_pend || (i_flush && r_state != IDLE));
            r_rd_vld     <= w_rd_en;
            r_rd_last    <= w_rd_end;
            r_wr_done    <= w_wr_end;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] r_rd_line_cnt, r_wr_line_cnt;

    assign o_rd_line_cnt = r_rd_line_cnt;
    assign o_wr_line_cnt = r_wr_line_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_line_cnt <= '0;
            r_wr_line_cnt <= '0;
        end else begin
            if (w_rd_end && r_rd_line_cnt != '1)
                r_rd_line_cnt <= r_rd_line_cnt + 32'd1;
            if (w_wr_end && r_wr_line_cnt != '1)
                r_wr_line_cnt <= r_wr_line_cnt + 32'd1;
        end
    end
`endif

    main_mem_array #(
        .AW    (ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .OFF_W (OFF_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  ({r_line, r_beat}),
        .o_rd_data  (o_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  ({r_line, r_beat}),
        .i_wr_data  (i_wr_data),
        .i_clr_en   (w_clr_en),
        .i_clr_line (r_fl_line)
    );

endmodule

// File: tb/tb_main_mem_burst.sv
// tb_main_mem_burst: randomized self-checking bench for main_mem_burst against a word-array reference model.
module tb_main_mem_burst;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, i_flush, i_req_vld, o_req_rdy, i_req_we, i_wr_vld;
    logic        o_rd_vld, o_rd_last, o_wr_done, o_busy;
    logic [15:0] i_req_addr;
    logic [7:0]  i_wr_data, o_rd_data;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0] o_rd_line_cnt, o_wr_line_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    int n_wr    = 0;

    logic [7:0] mdl [65536];
    bit         kn  [65536];

    always #5 clk = ~clk;

    main_mem_burst #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .LINE_WORDS (4),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_req_vld  (i_req_vld),
        .o_req_rdy  (o_req_rdy),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_wr_data  (i_wr_data),
        .i_wr_vld   (i_wr_vld),
        .o_rd_data  (o_rd_data),
        .o_rd_vld   (o_rd_vld),
        .o_rd_last  (o_rd_last),
        .o_wr_done  (o_wr_done),
        .o_busy     (o_busy)
`ifdef MAIN_MEM_STATS_EN
        ,
        .o_rd_line_cnt (o_rd_line_cnt),
        .o_wr_line_cnt (o_wr_line_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (!o_req_rdy && t < 40000) begin
            tick();
            t++;
        end
        check("req_rdy_wait", 32'(o_req_rdy), 32'd1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int plen, input logic [15:0] pat);
        int beat = 0;
        int idx  = 0;
        wait_rdy();
        i_req_vld  = 1'b1;
        i_req_we   = 1'b1;
        i_req_addr = a;
        tick();
        i_req_vld  = 1'b0;
        while (beat < 4 && idx < 200) begin
            check("wr_busy", 32'(o_busy), 32'd1);
            check("wr_done_early", 32'(o_wr_done), 32'd0);
            i_wr_vld  = plen > 0 ? pat[idx % plen] : ($urandom_range(0, 3) != 0);
            i_wr_data = d[8*beat +: 8];
            tick();
            if (i_wr_vld) begin
                mdl[{a[15:2], 2'(beat)}] = d[8*beat +: 8];
                kn[{a[15:2], 2'(beat)}]  = 1'b1;
                beat++;
            end
            idx++;
        end
        i_wr_vld = 1'b0;
        n_wr++;
        check("wr_done", 32'(o_wr_done), 32'd1);
        check("wr_idle", 32'(o_busy), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input int fl_at);
        logic [15:0] w;
        wait_rdy();
        i_req_vld  = 1'b1;
        i_req_we   = 1'b0;
        i_req_addr = a;
        tick();
        i_req_vld  = 1'b0;
        check("wr_done_pulse", 32'(o_wr_done), 32'd0);
        for (int c = 0; c < RD_LAT; c++) begin
            check("rd_lat", 32'(o_rd_vld), 32'd0);
            check("rd_busy", 32'(o_busy), 32'd1);
            tick();
        end
        w = a;
        for (int k = 0; k < 4; k++) begin
            w = {a[15:2], 2'(k)};
            check("rd_vld", 32'(o_rd_vld), 32'd1);
            check("rd_last", 32'(o_rd_last), 32'(k == 3));
            if (kn[w])
                check("rd_data", 32'(o_rd_data), 32'(mdl[w]));
            if (k == 3)
                check("rd_rdy_end", 32'(o_req_rdy), 32'(fl_at < 0));
            i_flush = (k == fl_at);
            tick();
        end
        i_flush = 1'b0;
        n_rd++;
        check("rd_end", 32'(o_rd_vld), 32'd0);
        if (kn[w])
            check("rd_hold", 32'(o_rd_data), 32'(mdl[w]));
    endtask

    task automatic wait_flush();
        int t   = 0;
        int cnt = 0;
        while (!o_busy && t < 8) begin
            tick();
            t++;
        end
        check("flush_busy", 32'(o_busy), 32'd1);
        check("flush_rdy", 32'(o_req_rdy), 32'd0);
        while (o_busy && cnt < 20000) begin
            cnt++;
            tick();
        end
        check("flush_len", 32'(cnt), 32'd16384);
        for (int i = 0; i < 65536; i++) begin
            mdl[i] = 8'h00;
            kn[i]  = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] a;
        rst        = 1'b1;
        i_flush    = 1'b0;
        i_req_vld  = 1'b0;
        i_req_we   = 1'b0;
        i_req_addr = '0;
        i_wr_data  = '0;
        i_wr_vld   = 1'b0;
        #1;
        check("rst_rdy", 32'(o_req_rdy), 32'd0);
        tick();
        tick();
        check("rst_rd_vld", 32'(o_rd_vld), 32'd0);
        check("rst_rd_last", 32'(o_rd_last), 32'd0);
        check("rst_wr_done", 32'(o_wr_done), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);
        check("rst_rdy_hold", 32'(o_req_rdy), 32'd0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 32'(o_req_rdy), 32'd1);

        do_write(16'h0010, 32'hA3A2_A1A0, 4, 16'h000F);
        do_read(16'h0013, -1);

        do_write(16'h0040, 32'h4433_2211, 7, 16'b101_1001);
        do_read(16'h0041, -1);

        do_write(16'h0000, 32'h0F0E_0D0C, 0, 16'h0);
        do_write(16'hFFFC, 32'hDDCC_BBAA, 0, 16'h0);
        do_read(16'hFFFF, -1);
        do_read(16'h0000, -1);

        do_read(16'h0010, 1);
        wait_flush();
        do_read(16'h0010, -1);

        do_write(16'hFFFC, 32'h7856_3412, 0, 16'h0);
        wait_rdy();
        i_flush    = 1'b1;
        i_req_vld  = 1'b1;
        i_req_we   = 1'b0;
        i_req_addr = 16'hFFFC;
        #1;
        check("coll_rdy", 32'(o_req_rdy), 32'd0);
        tick();
        i_flush = 1'b0;
        wait_flush();
        do_read(16'hFFFC, -1);

        for (int i = 0; i < 24; i++) begin
            a = 16'h0100 | 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0)
                a = 16'hFFFC | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 0, 16'h0);
            else
                do_read(a, -1);
        end
`ifdef MAIN_MEM_STATS_EN
        check("rd_cnt", o_rd_line_cnt, 32'(n_rd));
        check("wr_cnt", o_wr_line_cnt, 32'(n_wr));
`endif

        do_write(16'h0020, 32'h0403_0201, 0, 16'h0);
        wait_rdy();
        i_req_vld  = 1'b1;
        i_req_we   = 1'b1;
        i_req_addr = 16'h0020;
        tick();
        i_req_vld  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_wr_vld  = 1'b1;
            i_wr_data = 8'hB0 + 8'(k);
            tick();
            mdl[16'h0020 + 16'(k)] = 8'hB0 + 8'(k);
        end
        i_wr_vld = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_mid_rdy", 32'(o_req_rdy), 32'd0);
        tick();
        rst = 1'b0;
        n_rd = 0;
        n_wr = 0;
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_wr_done", 32'(o_wr_done), 32'd0);
        check("rst_mid_rd_vld", 32'(o_rd_vld), 32'd0);
        #1;
        check("rst_mid_rdy_after", 32'(o_req_rdy), 32'd1);
`ifdef MAIN_MEM_STATS_EN
        check("rst_rd_cnt", o_rd_line_cnt, 32'd0);
        check("rst_wr_cnt", o_wr_line_cnt, 32'd0);
`endif
        do_read(16'h0022, -1);
`ifdef MAIN_MEM_STATS_EN
        check("rd_cnt_after", o_rd_line_cnt, 32'(n_rd));
        check("wr_cnt_after", o_wr_line_cnt, 32'(n_wr));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
